fcmp_pipe: RTL and testbench
============================

// Module: fcmp_pipe
// PURPOSE
//   Pipelined, parametrised comparator for FloPoCo-format floats: {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
//   Evaluates one runtime-selected predicate per transaction and reports raw lt/eq/gt flags plus unordered.
//   Uses valid/ready streaming with back-pressure and sits between the HLS datapath scheduler and compare/select consumers.
//   Successor to the fixed 4/3, predicate-LT-only, purely combinational compare.
// PARAMETERS
//   WE      4  exponent width (>=2)
//   WF      3  fraction width (>=1)
//   STAGES  2  pipeline register stages, legal 1..4 (latency in cycles)
// PORTS
//   clk        in   1          clock, rising edge
//   rst_n      in   1          reset, asynchronous assert, active-low
//   in_valid   in   1          X/Y/op valid
//   in_ready   out  1          block accepts a transaction this cycle
//   op         in   3          predicate: 0 EQ,1 LT,2 LE,3 GT,4 GE,5 NE,6 ORD,7 UNO
//   X          in   WE+WF+3    operand X
//   Y          in   WE+WF+3    operand Y
//   out_valid  out  1          result/flags/unordered valid
//   out_ready  in   1          consumer accepts the output this cycle
//   result     out  1          predicate value
//   flags      out  3          {gt,eq,lt}, forced to 000 when unordered
//   unordered  out  1          X or Y is NaN
// BEHAVIOUR
//   Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//   Reset: clears every stage valid bit; out_valid=0, result=0, flags=000, unordered=0.
//     Payload registers are also cleared. Reset mid-stream drops all in-flight transactions; nothing is replayed.
//   Decode: exc 00=zero, 01=normal, 10=inf, 11=NaN.
//     Zero ignores sign and fraction, so +0 == -0.
//     Inf ignores exponent and fraction. NaN is unordered with everything, including itself.
//   Ordering for non-NaN operands: -inf < -normal < zero < +normal < +inf.
//     Same-sign normals compare by the unsigned {exp,frac}; the sense is inverted for negatives.
//   Predicates on ordered inputs: the usual definitions from lt/eq/gt.
//     On unordered inputs: EQ/LT/LE/GT/GE=0, NE=1, ORD=0, UNO=1.
//   Pipeline partitioning:
//     stage 1 registers the decode, the {exp,frac} magnitude compare and op;
//     the final stage registers result/flags/unordered.
//     For STAGES=1 everything is computed combinationally into one register stage.
//     Extra stages (3,4) are plain delay registers.
//   Handshake:
//     a transfer occurs on in_valid&in_ready, and on out_valid&out_ready;
//     stage k loads when it is empty or stage k+1 loads; the last stage loads when empty or out_ready=1.
//     in_ready = stage-1 load enable, so it is combinational from out_ready.
//     Bubbles collapse; throughput is 1/cycle when out_ready=1.
//     Latency is exactly STAGES cycles from accept to out_valid when there is no stall.
//   Outputs stay stable while out_valid=1 and out_ready=0. Order is preserved; no loss, no duplication.
//   Simultaneous accept and emit while full is legal and keeps occupancy constant.
//   in_valid=0 or op/X/Y changes while not accepted: no effect.
// TESTING (WE=4, WF=3; 1.0=0x138, 2.0=0x140, -1.0=0x1B8, +0=0x000, -0=0x080, +inf=0x200, -inf=0x280, NaN=0x300)
//   1. op=LT X=0x138 Y=0x140, out_ready=1 -> after 2 cycles out_valid=1, result=1, flags=001, unordered=0.
//   2. op=EQ X=0x000 Y=0x080 -> result=1, flags=010. Then op=LT X=0x1B8 Y=0x000 -> result=1.
//   3. X=0x300 Y=0x138 with op=EQ, NE, UNO, LE -> results 0,1,1,0; flags=000; unordered=1 for each.
//   4. op=GT X=0x200 Y=0x140 -> result=1; op=EQ X=0x280 Y=0x280 -> result=1; op=LT same operands -> result=0.
//   5. Back-pressure: 10 back-to-back LT ops, out_ready=0 for 4 mid-stream cycles.
//      -> in_ready drops once 2 are held; all 10 results emerge in order, outputs stable while stalled.
//   6. Reset: rst_n=0 with 2 transactions in flight -> out_valid=0 immediately (async);
//      after release there is no output until a new transaction is accepted, which emerges 2 cycles later.

Source files
------------

// File: rtl/fcmp_pipe_if.sv
// Streaming bundle for fcmp_pipe: operand/predicate input channel and result output channel.
// The operand width is {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
interface fcmp_pipe_if #(
    parameter int WE = 4,
    parameter int WF = 3
);
    localparam int W = WE + WF + 3;

    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         out_valid;
    logic         out_ready;
    logic         result;
    logic [2:0]   flags;
    logic         unordered;

    modport master (
        output in_valid, op, X, Y, out_ready,
        input  in_ready, out_valid, result, flags, unordered
    );

    modport slave (
        input  in_valid, op, X, Y, out_ready,
        output in_ready, out_valid, result, flags, unordered
    );
endinterface

// File: rtl/fcmp_pipe.sv
// Pipelined FloPoCo float comparator with runtime predicate select and valid/ready flow control.
// Stage 1 holds decode + magnitude compare; the next stage holds the predicate; later stages only delay.
module fcmp_pipe #(
    parameter int WE     = 4,
    parameter int WF     = 3,
    parameter int STAGES = 2
) (
    input logic         clk,
    input logic         rst_n,
    fcmp_pipe_if.slave  bus
);
    localparam int W = WE + WF + 3;

    typedef struct packed {
        logic [1:0] ex;
        logic [1:0] ey;
        logic       sx;
        logic       sy;
        logic       mlt;
        logic       meq;
        logic [2:0] op;
    } dec_t;

    function automatic dec_t decode(input logic [2:0] p, input logic [W-1:0] x, input logic [W-1:0] y);
        dec_t d;
        d.ex  = x[W-1 -: 2];
        d.ey  = y[W-1 -: 2];
        d.sx  = x[WE+WF];
        d.sy  = y[WE+WF];
        d.mlt = (x[WE+WF-1:0] <  y[WE+WF-1:0]);
        d.meq = (x[WE+WF-1:0] == y[WE+WF-1:0]);
        d.op  = p;
        return d;
    endfunction

    // Coarse class order: -inf < -normal < zero < +normal < +inf (NaN handled separately).
    function automatic logic [2:0] rank(input logic [1:0] e, input logic s);
        logic [2:0] r;
        case (e)
            2'b00:   r = 3'd2;
            2'b01:   r = s ? 3'd1 : 3'd3;
            2'b10:   r = s ? 3'd0 : 3'd4;
            default: r = 3'd2;
        endcase
        return r;
    endfunction

    // Returns {result, gt, eq, lt, unordered}.
    function automatic logic [4:0] evaluate(input dec_t d);
        logic       uno, lt, eq, gt, res;
        logic [2:0] rx, ry;
        uno = (d.ex == 2'b11) || (d.ey == 2'b11);
        rx  = rank(d.ex, d.sx);
        ry  = rank(d.ey, d.sy);
        if (uno) begin
            lt = 1'b0; eq = 1'b0; gt = 1'b0;
        end else if (rx != ry) begin
            lt = (rx < ry); eq = 1'b0; gt = (rx > ry);
        end else if (d.ex == 2'b01) begin
            // Equal rank on normals means equal signs; negatives invert the magnitude sense.
            eq = d.meq;
            if (d.sx) begin
                lt = !d.mlt && !d.meq; gt = d.mlt;
            end else begin
                lt = d.mlt;            gt = !d.mlt && !d.meq;
            end
        end else begin
            lt = 1'b0; eq = 1'b1; gt = 1'b0;
        end
        case (d.op)
            3'd0:    res = eq;
            3'd1:    res = lt;
            3'd2:    res = lt | eq;
            3'd3:    res = gt;
            3'd4:    res = gt | eq;
            3'd5:    res = !eq;
            3'd6:    res = !uno;
            default: res = uno;
        endcase
        return {res, gt, eq, lt, uno};
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] ld_s;
    logic [STAGES:0]   vin_s;
    logic [4:0]        out_s;
    dec_t              dec_d_s;

    assign dec_d_s = decode(bus.op, bus.X, bus.Y);
    assign vin_s   = {v_q, bus.in_valid};

    // A stage may load when any stage at or downstream of it is empty, or the consumer takes the output.
    for (genvar k = 0; k < STAGES; k++) begin : g_ld
        assign ld_s[k] = bus.out_ready | ~(&v_q[STAGES-1:k]);
    end

    // Stage valid bits shift forward on their load enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld_s[k]) begin
                    v_q[k] <= vin_s[k];
                end else begin
                    v_q[k] <= v_q[k];
                end
            end
        end
    end

    if (STAGES == 1) begin : g_one
        logic [4:0] res_q;

        // Single stage: decode and predicate evaluated combinationally into one register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q <= 5'd0;
            end else if (ld_s[0] && bus.in_valid) begin
                res_q <= evaluate(dec_d_s);
            end else begin
                res_q <= res_q;
            end
        end

        assign out_s = res_q;
    end else begin : g_multi
        dec_t       dec_q;
        logic [4:0] res_q [1:STAGES-1];

        // Stage 1 captures the decoded operands, magnitude compare and predicate select.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dec_q <= '0;
            end else if (ld_s[0] && bus.in_valid) begin
                dec_q <= dec_d_s;
            end else begin
                dec_q <= dec_q;
            end
        end

        // Stage 2 evaluates the predicate; any further stages are plain delays.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 1; k < STAGES; k++) res_q[k] <= 5'd0;
            end else begin
                if (ld_s[1] && v_q[0]) res_q[1] <= evaluate(dec_q);
                for (int k = 2; k < STAGES; k++) begin
                    if (ld_s[k] && v_q[k-1]) res_q[k] <= res_q[k-1];
                end
            end
        end

        assign out_s = res_q[STAGES-1];
    end

    assign bus.in_ready  = ld_s[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.result    = out_s[4];
    assign bus.flags     = out_s[3:1];
    assign bus.unordered = out_s[0];
endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe (WE=4, WF=3, STAGES=2): vector table, back-pressure stream, async reset.
module tb_fcmp_pipe;
    localparam int WE     = 4;
    localparam int WF     = 3;
    localparam int STAGES = 2;
    localparam int W      = WE + WF + 3;
    localparam int NVEC   = 22;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fcmp_pipe_if #(.WE(WE), .WF(WF)) bus ();

    fcmp_pipe #(.WE(WE), .WF(WF), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         res;
        logic [2:0]   flags;
        logic         uno;
    } vec_t;

    vec_t       tbl [NVEC];
    logic [4:0] sb [$];
    logic [4:0] exp_cur;
    logic [4:0] hold_d;
    logic       hold_v;
    int         total = 0;
    int         bad   = 0;
    int         nout  = 0;

    // Signed ordering key for non-NaN operands.
    function automatic int key(input logic [W-1:0] v);
        int m;
        m = int'(v[WE+WF-1:0]) + 1;
        case (v[W-1:W-2])
            2'b00:   return 0;
            2'b01:   return v[WE+WF] ? -m : m;
            default: return v[WE+WF] ? -(1 << (WE+WF+1)) : (1 << (WE+WF+1));
        endcase
    endfunction

    function automatic logic [4:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic u, lt, eq, gt, r;
        u  = (x[W-1:W-2] == 2'b11) || (y[W-1:W-2] == 2'b11);
        lt = !u && (key(x) <  key(y));
        eq = !u && (key(x) == key(y));
        gt = !u && (key(x) >  key(y));
        case (o)
            3'd0:    r = eq;
            3'd1:    r = lt;
            3'd2:    r = lt | eq;
            3'd3:    r = gt;
            3'd4:    r = gt | eq;
            3'd5:    r = !eq;
            3'd6:    r = !u;
            default: r = u;
        endcase
        return {r, gt, eq, lt, u};
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [4:0] e);
        int   n;
        logic acc;
        bus.op = o; bus.X = x; bus.Y = y; exp_cur = e; bus.in_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        chk("accept", int'(acc), 1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, sb.size(), 0);
    endtask

    task automatic latency(input string nm);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 10);
        chk(nm, lat, STAGES);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r32;
        logic [W-1:0] xr, yr;
        int  nbase;
        logic saw;

        bus.in_valid = 1'b0; bus.op = 3'd0; bus.X = '0; bus.Y = '0;
        bus.out_ready = 1'b1; exp_cur = 5'd0; hold_v = 1'b0; hold_d = 5'd0;

        tbl[0]  = '{3'd1, 10'h138, 10'h140, 1'b1, 3'b001, 1'b0};
        tbl[1]  = '{3'd0, 10'h000, 10'h080, 1'b1, 3'b010, 1'b0};
        tbl[2]  = '{3'd1, 10'h1B8, 10'h000, 1'b1, 3'b001, 1'b0};
        tbl[3]  = '{3'd0, 10'h300, 10'h138, 1'b0, 3'b000, 1'b1};
        tbl[4]  = '{3'd5, 10'h300, 10'h138, 1'b1, 3'b000, 1'b1};
        tbl[5]  = '{3'd7, 10'h300, 10'h138, 1'b1, 3'b000, 1'b1};
        tbl[6]  = '{3'd2, 10'h300, 10'h138, 1'b0, 3'b000, 1'b1};
        tbl[7]  = '{3'd3, 10'h200, 10'h140, 1'b1, 3'b100, 1'b0};
        tbl[8]  = '{3'd0, 10'h280, 10'h280, 1'b1, 3'b010, 1'b0};
        tbl[9]  = '{3'd1, 10'h280, 10'h280, 1'b0, 3'b010, 1'b0};
        tbl[10] = '{3'd4, 10'h140, 10'h138, 1'b1, 3'b100, 1'b0};
        tbl[11] = '{3'd6, 10'h138, 10'h140, 1'b1, 3'b001, 1'b0};
        tbl[12] = '{3'd1, 10'h1C0, 10'h1B8, 1'b1, 3'b001, 1'b0};
        tbl[13] = '{3'd3, 10'h1B8, 10'h1C0, 1'b1, 3'b100, 1'b0};
        tbl[14] = '{3'd7, 10'h300, 10'h300, 1'b1, 3'b000, 1'b1};
        tbl[15] = '{3'd6, 10'h300, 10'h300, 1'b0, 3'b000, 1'b1};
        tbl[16] = '{3'd2, 10'h138, 10'h138, 1'b1, 3'b010, 1'b0};
        tbl[17] = '{3'd5, 10'h200, 10'h280, 1'b1, 3'b100, 1'b0};
        tbl[18] = '{3'd1, 10'h13F, 10'h138, 1'b0, 3'b100, 1'b0};
        tbl[19] = '{3'd3, 10'h080, 10'h1B8, 1'b1, 3'b100, 1'b0};
        tbl[20] = '{3'd0, 10'h000, 10'h07F, 1'b1, 3'b010, 1'b0};
        tbl[21] = '{3'd0, 10'h200, 10'h27F, 1'b1, 3'b010, 1'b0};

        // Output monitor / scoreboard
        fork
            forever begin
                logic [4:0] got, e;
                @(negedge clk);
                got = {bus.result, bus.flags, bus.unordered};
                if (hold_v) begin
                    total++;
                    if (!(bus.out_valid && got == hold_d)) begin
                        bad++;
                        $display("FAIL stall_hold got v=%b d=%b exp v=1 d=%b", bus.out_valid, got, hold_d);
                    end
                end
                hold_v = bus.out_valid && !bus.out_ready;
                hold_d = got;
                if (rst_n && bus.in_valid && bus.in_ready) sb.push_back(exp_cur);
                if (bus.out_valid && bus.out_ready) begin
                    total++;
                    nout++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL out_unexpected got=%b exp=none", got);
                    end else begin
                        e = sb.pop_front();
                        if (got !== e) begin
                            bad++;
                            $display("FAIL out[%0d] got=%b exp=%b", nout, got, e);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk); #1;
        chk("reset_state", int'({bus.out_valid, bus.result, bus.flags, bus.unordered}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single transaction: exact latency
        drive(3'd1, 10'h138, 10'h140, 5'b1_001_0);
        bus.in_valid = 1'b0;
        latency("latency");
        drain("drain_first");

        // Vector table, back-to-back
        for (int i = 0; i < NVEC; i++)
            drive(tbl[i].op, tbl[i].x, tbl[i].y, {tbl[i].res, tbl[i].flags, tbl[i].uno});
        bus.in_valid = 1'b0;
        drain("drain_table");

        // Back-pressure: 10 LT ops with a 4-cycle consumer stall mid-stream
        nbase = nout;
        saw   = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    r32 = $urandom; xr = r32[W-1:0];
                    r32 = $urandom; yr = r32[W-1:0];
                    drive(3'd1, xr, yr, model(3'd1, xr, yr));
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk); #1;
                bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (!bus.in_ready) saw = 1'b1;
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        chk("in_ready_drop", int'(saw), 1);
        drain("drain_stream");
        chk("stream_count", nout - nbase, 10);

        // Async reset with two transactions in flight
        drive(3'd3, 10'h200, 10'h140, model(3'd3, 10'h200, 10'h140));
        drive(3'd1, 10'h138, 10'h140, model(3'd1, 10'h138, 10'h140));
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset", int'({bus.out_valid, bus.result, bus.flags, bus.unordered}), 0);
        sb.delete();
        hold_v = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nbase = nout;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", int'(bus.out_valid), 0);
        end
        @(posedge clk); #1;
        chk("post_reset_no_out", nout - nbase, 0);
        drive(3'd0, 10'h138, 10'h138, model(3'd0, 10'h138, 10'h138));
        bus.in_valid = 1'b0;
        latency("latency_after_reset");
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
